// File: rtl/load_store_unit.sv
// Execute-to-writeback load/store stage: turns an ALU result into at most one
// memory transaction and emits one writeback pulse per accepted instruction.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_result,
    input  logic [31:0] in_wdata,
    input  logic        in_ren,
    input  logic        in_wen,
    input  logic [1:0]  in_size,
    input  logic        in_sign,
    output logic        busy,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    output logic        req_wen,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wmask,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [1:0]  out_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;
    localparam logic [1:0] ERR_ILL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                req_valid_q, req_valid_d;
    logic [DATA_W-1:0]   req_addr_q, req_addr_d;
    logic                req_wen_q, req_wen_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic [MASK_W-1:0]   req_wmask_q, req_wmask_d;
    logic [1:0]          ld_off_q, ld_off_d;
    logic [1:0]          ld_size_q, ld_size_d;
    logic                ld_sign_q, ld_sign_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [1:0]          out_err_q, out_err_d;

    logic                illegal_c;
    logic                misaligned_c;
    logic                timeout_c;
    logic [MASK_W-1:0]   lane_mask_c;
    logic [DATA_W-1:0]   lane_wdata_c;

    // Select the addressed byte/half from the read word and extend it.
    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] rdata,
                                                  input logic [1:0]        off,
                                                  input logic [1:0]        size,
                                                  input logic              sign);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   extract = sign ? {{24{b[7]}}, b} : {24'b0, b};
            2'b01:   extract = sign ? {{16{h[15]}}, h} : {16'b0, h};
            default: extract = rdata;
        endcase
    endfunction

    always_comb begin
        illegal_c    = (in_ren && in_wen) || (in_size == 2'b11);
        misaligned_c = ((in_size == 2'b01) && in_result[0]) ||
                       ((in_size == 2'b10) && (in_result[1:0] != 2'b00));
        timeout_c    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        case (in_size)
            2'b00: begin
                lane_mask_c  = 4'b0001 << in_result[1:0];
                lane_wdata_c = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                lane_mask_c  = 4'b0011 << in_result[1:0];
                lane_wdata_c = {2{in_wdata[15:0]}};
            end
            default: begin
                lane_mask_c  = 4'b1111;
                lane_wdata_c = in_wdata;
            end
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_wen_d   = req_wen_q;
        req_wdata_d = req_wdata_q;
        req_wmask_d = req_wmask_q;
        ld_off_d    = ld_off_q;
        ld_size_d   = ld_size_q;
        ld_sign_d   = ld_sign_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ld_off_d  = in_result[1:0];
                    ld_size_d = in_size;
                    ld_sign_d = in_sign;
                    if (!in_ren && !in_wen) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = in_result;
                        out_err_d   = ERR_OK;
                    end else if (illegal_c) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = '0;
                        out_err_d   = ERR_ILL;
                    end else if (misaligned_c) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = '0;
                        out_err_d   = ERR_MIS;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = '0;
                        req_valid_d = 1'b1;
                        req_addr_d  = {in_result[31:2], 2'b00};
                        req_wen_d   = in_wen;
                        req_wdata_d = in_wen ? lane_wdata_c : '0;
                        req_wmask_d = in_wen ? lane_mask_c : '0;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // The budget covers REQ and WAIT; a late grant cannot extend it.
                if (timeout_c) begin
                    state_d     = S_DONE;
                    req_valid_d = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    out_err_d   = ERR_TMO;
                end else if (req_ready) begin
                    state_d     = S_WAIT;
                    req_valid_d = 1'b0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (resp_valid) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = req_wen_q ? '0 : extract(resp_rdata, ld_off_q, ld_size_q, ld_sign_q);
                    out_err_d   = ERR_OK;
                end else if (timeout_c) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    out_err_d   = ERR_TMO;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
            ld_off_q    <= '0;
            ld_size_q   <= '0;
            ld_sign_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_wen_q   <= req_wen_d;
            req_wdata_q <= req_wdata_d;
            req_wmask_q <= req_wmask_d;
            ld_off_q    <= ld_off_d;
            ld_size_q   <= ld_size_d;
            ld_sign_q   <= ld_sign_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    assign busy      = busy_q;
    assign req_valid = req_valid_q;
    assign req_addr  = req_addr_q;
    assign req_wen   = req_wen_q;
    assign req_wdata = req_wdata_q;
    assign req_wmask = req_wmask_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model plus a per-cycle compare
// process, driven by directed vectors with literal expectations.
module tb_load_store_unit;

    localparam int unsigned TO  = 6;
    localparam int unsigned CW  = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_result = '0;
    logic [31:0] in_wdata = '0;
    logic        in_ren = 1'b0;
    logic        in_wen = 1'b0;
    logic [1:0]  in_size = '0;
    logic        in_sign = 1'b0;
    logic        busy;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_rdata = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_err;

    load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_result(in_result), .in_wdata(in_wdata),
        .in_ren(in_ren), .in_wen(in_wen), .in_size(in_size), .in_sign(in_sign),
        .busy(busy),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_err(out_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        mem;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] data;
        logic [1:0]  err;
    } exp_t;

    exp_t        exp_out_q[$];
    exp_t        exp_req_q[$];
    exp_t        cmp_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          rv_cycles = 0;
    logic        prev_rv = 1'b0;
    logic [31:0] seen_addr = '0;
    logic [31:0] seen_wdata = '0;
    logic [3:0]  seen_wmask = '0;

    // What one instruction must produce, from alignment arithmetic and byte counts.
    function automatic exp_t model(input logic [31:0] res, input logic [31:0] wd,
                                   input logic ren, input logic wen,
                                   input logic [1:0] size, input logic sign,
                                   input logic [31:0] rdata);
        exp_t        e;
        int          off;
        int          nbytes;
        logic [31:0] v;
        e   = '0;
        off = int'(res % 32'd4);
        if (!ren && !wen) begin
            e.data = res;
        end else if ((ren && wen) || size == 2'b11) begin
            e.err = 2'd3;
        end else begin
            nbytes = 1 << int'(size);
            if (off % nbytes != 0) begin
                e.err = 2'd1;
            end else begin
                e.mem  = 1'b1;
                e.addr = res - 32'(off);
                e.wen  = wen;
                if (wen) begin
                    e.wmask = 4'(((1 << nbytes) - 1) << off);
                    if (nbytes == 1)      e.wdata = 32'(wd[7:0]) * 32'h0101_0101;
                    else if (nbytes == 2) e.wdata = 32'(wd[15:0]) * 32'h0001_0001;
                    else                  e.wdata = wd;
                end else begin
                    v = rdata >> (8 * off);
                    if (nbytes < 4) begin
                        v = v % (32'd1 << (8 * nbytes));
                        if (sign && v >= (32'd1 << (8 * nbytes - 1)))
                            v = v - (32'd1 << (8 * nbytes));
                    end
                    e.data = v;
                end
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the writeback and request ports against the model queues.
    always @(negedge clock) begin
        if (reset) begin
            prev_rv = 1'b0;
        end else begin
            if (out_valid) begin
                chk("out_valid_expected", 32'(out_valid), 32'(exp_out_q.size() > 0));
                if (exp_out_q.size() > 0) begin
                    cmp_e = exp_out_q.pop_front();
                    chk("out_data", out_data, cmp_e.data);
                    chk("out_err", 32'(out_err), 32'(cmp_e.err));
                end
            end
            if (req_valid) begin
                rv_cycles++;
                chk("req_valid_expected", 32'(req_valid), 32'(exp_req_q.size() > 0));
                if (exp_req_q.size() > 0) begin
                    cmp_e = exp_req_q[0];
                    chk("req_addr", req_addr, cmp_e.addr);
                    chk("req_wen", 32'(req_wen), 32'(cmp_e.wen));
                    chk("req_wmask", 32'(req_wmask), 32'(cmp_e.wmask));
                    if (cmp_e.wen) chk("req_wdata", req_wdata, cmp_e.wdata);
                end
            end
            if (prev_rv && !req_valid && exp_req_q.size() > 0) void'(exp_req_q.pop_front());
            prev_rv = req_valid;
        end
    end

    task automatic issue(input logic [31:0] res, input logic [31:0] wd, input logic ren,
                         input logic wen, input logic [1:0] size, input logic sign);
        in_valid  = 1'b1;
        in_result = res;
        in_wdata  = wd;
        in_ren    = ren;
        in_wen    = wen;
        in_size   = size;
        in_sign   = sign;
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        in_result = 32'hDEAD_0000;
        in_wdata  = 32'h0BAD_0BAD;
    endtask

    task automatic serve(input int ready_lat, input logic [31:0] rdata);
        int k;
        k = 0;
        while (!req_valid && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("req_seen", 32'(req_valid), 32'd1);
        seen_addr  = req_addr;
        seen_wdata = req_wdata;
        seen_wmask = req_wmask;
        repeat (ready_lat) @(posedge clock);
        #1;
        req_ready = 1'b1;
        @(posedge clock);
        #1;
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_rdata = rdata;
        @(posedge clock);
        #1;
        resp_valid = 1'b0;
        resp_rdata = $urandom;
    endtask

    task automatic wait_out(input int max_c, output int lat);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!out_valid && lat < max_c);
        if (!out_valid) chk("out_valid_bound", 32'(out_valid), 32'd1);
    endtask

    task automatic do_op(input logic [31:0] res, input logic [31:0] wd, input logic ren,
                         input logic wen, input logic [1:0] size, input logic sign,
                         input logic [31:0] rdata, input int ready_lat, output int lat);
        exp_t e;
        int   l;
        e = model(res, wd, ren, wen, size, sign, rdata);
        exp_out_q.push_back(e);
        if (e.mem) exp_req_q.push_back(e);
        issue(res, wd, ren, wen, size, sign);
        if (e.mem) begin
            fork
                serve(ready_lat, rdata);
                wait_out(30, l);
            join
        end else begin
            wait_out(30, l);
        end
        lat = l;
        @(posedge clock);
        #1;
    endtask

    task automatic count_out(input int cycles, output int ov);
        ov = 0;
        repeat (cycles) begin
            @(negedge clock);
            ov += int'(out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   ov;
        int   rv0;
        exp_t e;

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_req_addr", req_addr, 32'd0);
        chk("rst_req_wen", 32'(req_wen), 32'd0);
        chk("rst_req_wdata", req_wdata, 32'd0);
        chk("rst_req_wmask", 32'(req_wmask), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;

        rv0 = rv_cycles;
        do_op(32'h1234_5678, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 0, lat);
        chk("pt_latency", 32'(lat), 32'd1);
        chk("pt_data_held", out_data, 32'h1234_5678);
        chk("pt_err", 32'(out_err), 32'd0);
        chk("pt_no_request", 32'(rv_cycles - rv0), 32'd0);

        do_op(32'h8000_0003, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h80FF_0011, 0, lat);
        chk("lb_latency", 32'(lat), 32'd3);
        chk("lb_data", out_data, 32'hFFFF_FF80);
        chk("lb_addr", seen_addr, 32'h8000_0000);
        chk("lb_wmask", 32'(seen_wmask), 32'd0);

        do_op(32'h8000_0003, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h80FF_0011, 0, lat);
        chk("lbu_data", out_data, 32'h0000_0080);

        do_op(32'h8000_0002, 32'hAAAA_BEEF, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0, 3, lat);
        chk("sh_latency", 32'(lat), 32'd6);
        chk("sh_wmask", 32'(seen_wmask), 32'hC);
        chk("sh_wdata", seen_wdata, 32'hBEEF_BEEF);
        chk("sh_data", out_data, 32'h0);
        chk("sh_err", 32'(out_err), 32'd0);

        rv0 = rv_cycles;
        do_op(32'h8000_0001, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 0, lat);
        chk("mis_latency", 32'(lat), 32'd1);
        chk("mis_err", 32'(out_err), 32'd1);
        do_op(32'h8000_0000, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 0, lat);
        chk("size11_err", 32'(out_err), 32'd3);
        do_op(32'h8000_0000, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 0, lat);
        chk("renwen_err", 32'(out_err), 32'd3);
        do_op(32'h8000_0003, 32'h1111, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0, 0, lat);
        chk("mis_sh_err", 32'(out_err), 32'd1);
        chk("err_no_request", 32'(rv_cycles - rv0), 32'd0);

        do_op(32'h1000_0004, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1, lat);
        chk("lw_data", out_data, 32'hDEAD_BEEF);
        do_op(32'h1000_0006, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h8001_1234, 0, lat);
        chk("lh_data", out_data, 32'hFFFF_8001);
        do_op(32'h1000_0004, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h8001_1234, 0, lat);
        chk("lhu_data", out_data, 32'h0000_1234);
        do_op(32'h1000_0001, 32'h1234_5655, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 2, lat);
        chk("sb_wmask", 32'(seen_wmask), 32'h2);
        chk("sb_wdata", seen_wdata, 32'h5555_5555);
        do_op(32'h1000_0008, 32'hCAFE_F00D, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 0, lat);
        chk("sw_wmask", 32'(seen_wmask), 32'hF);
        chk("sw_wdata", seen_wdata, 32'hCAFE_F00D);

        // Request never granted: expires after TO cycles in REQ.
        e = model(32'h2000_0000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
        exp_req_q.push_back(e);
        e.data = 32'h0;
        e.err  = 2'd2;
        exp_out_q.push_back(e);
        issue(32'h2000_0000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
        wait_out(30, lat);
        chk("tmo_latency", 32'(lat), 32'(TO + 1));
        chk("tmo_err", 32'(out_err), 32'd2);
        chk("tmo_data", out_data, 32'h0);
        resp_valid = 1'b1;
        resp_rdata = 32'h7777_7777;
        repeat (2) @(posedge clock);
        #1 resp_valid = 1'b0;
        chk("tmo_req_dropped", 32'(req_valid), 32'd0);
        count_out(4, ov);
        chk("tmo_late_resp_ignored", 32'(ov), 32'd0);

        // Reset while waiting for the response.
        exp_req_q.push_back(model(32'h0000_0100, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0));
        issue(32'h0000_0100, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
        chk("rw_busy_req", 32'(busy), 32'd1);
        req_ready = 1'b1;
        @(posedge clock);
        #1 req_ready = 1'b0;
        chk("rw_busy_wait", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rw_req_valid", 32'(req_valid), 32'd0);
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_out_valid", 32'(out_valid), 32'd0);
        exp_req_q.delete();
        @(posedge clock);
        #1 reset = 1'b0;
        resp_valid = 1'b1;
        resp_rdata = 32'h1357_9BDF;
        @(posedge clock);
        #1 resp_valid = 1'b0;
        count_out(4, ov);
        chk("rw_stale_resp_ignored", 32'(ov), 32'd0);
        do_op(32'h0000_0100, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0BAD_F00D, 0, lat);
        chk("rw_fresh_latency", 32'(lat), 32'd3);
        chk("rw_fresh_data", out_data, 32'h0BAD_F00D);

        chk("exp_out_drained", 32'(exp_out_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Execute-to-writeback stage placed directly downstream of the ALU in the multi-cycle RV32 core.
- Consumes the ALU's registered result and its one-cycle valid pulse.
- For loads and stores, uses the result as the effective address and runs one transaction on a simple valid/ready memory port.
- Non-memory instructions pass the ALU result through to writeback; the unit emits one out_valid pulse per accepted instruction.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in REQ+WAIT before the transaction is aborted with a timeout error.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  input  1  single clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high; forces all state to reset values immediately.
- in_valid  input  1  one-cycle pulse; ALU result and controls are valid this cycle.
- in_result  input  32  ALU result: effective address for loads/stores, writeback value otherwise.
- in_wdata  input  32  store data (rs2).
- in_ren  input  1  load instruction.
- in_wen  input  1  store instruction.
- in_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- in_sign  input  1  sign-extend load data (LB/LH); 0 = zero-extend.
- busy  output  1  high in any state other than IDLE.
- req_valid  output  1  memory request valid.
- req_ready  input  1  memory accepts request.
- req_addr  output  32  word-aligned address {addr[31:2],2'b00}.
- req_wen  output  1  1 = write, 0 = read.
- req_wdata  output  32  lane-replicated store data.
- req_wmask  output  4  byte enables; 0000 for reads.
- resp_valid  input  1  read data valid, or write acknowledge.
- resp_rdata  input  32  read data word.
- out_valid  output  1  one-cycle pulse; writeback data ready.
- out_data  output  32  writeback value.
- out_err  output  2  00 ok, 01 misaligned, 10 timeout, 11 illegal op.

Behaviour:
- Reset (async): state=IDLE, counter=0. All outputs are 0: busy, req_valid, req_addr, req_wen, req_wdata, req_wmask, out_valid, out_data, out_err.
- Capture: in IDLE, in_valid registers all in_* signals. in_valid outside IDLE is ignored; upstream must not issue while busy.
- States: IDLE, REQ, WAIT, DONE.
- IDLE -> DONE:
  - in_ren=in_wen=0: pass-through, out_data=in_result, err=00.
  - in_ren=in_wen=1 or in_size=11: err=11, out_data=0.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0): err=01, out_data=0.
  - None of these cases issues a memory request.
- IDLE -> REQ: any other load or store.
- REQ:
  - req_valid=1; req_* held stable until the cycle req_valid && req_ready.
  - Handshake -> WAIT.
  - resp_valid is ignored in REQ; a response may arrive no earlier than the cycle after the handshake.
- WAIT:
  - req_valid=0.
  - resp_valid -> DONE. Loads: out_data = extracted rdata. Stores: out_data=0. err=00.
- Timeout:
  - Counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES without completion -> DONE with err=10, out_data=0, req_valid dropped.
  - A late resp_valid arriving afterwards is ignored (in IDLE or DONE).
- DONE: out_valid=1 for exactly one cycle, then -> IDLE. out_data and out_err hold their values until the next DONE.
- Latency:
  - Pass-through and error cases: out_valid is 1 cycle after in_valid.
  - Memory with req_ready=1 and the response one cycle later: out_valid is 3 cycles after in_valid.
- Store lanes (off=addr[1:0]):
  - byte: wmask=0001<<off, wdata={4{d[7:0]}}.
  - half: wmask=0011<<off, wdata={2{d[15:0]}}.
  - word: wmask=1111, wdata=d.
- Load extraction:
  - byte: rdata[8*off+:8].
  - half: rdata[16*off[1]+:16].
  - Extend to 32 bits by in_sign; word is passed unchanged.
- Reset mid-transaction: immediate IDLE, req_valid drops combinationally with the async clear, no out_valid. Any outstanding response arriving later is ignored.

Test Plan:
- Pass-through: in_valid, ren=wen=0, result=0x1234_5678 -> next cycle out_valid=1, out_data=0x1234_5678, err=00, req_valid never asserted.
- LB signed: addr=0x8000_0003, sign=1, resp_rdata=0x80FF_0011 -> req_addr=0x8000_0000, wmask=0000, out_data=0xFFFF_FF80. Repeat with sign=0 -> 0x0000_0080.
- SH: addr=0x8000_0002, wdata=0xAAAA_BEEF, req_ready low 3 cycles -> req_* stable throughout, wmask=1100, req_wdata=0xBEEF_BEEF, out_data=0, err=00.
- Misaligned LW: addr=0x8000_0001 -> no request, out_valid 1 cycle later, err=01. Also cover size=11 -> err=11.
- Timeout: TIMEOUT_CYCLES=4, req_ready held 0 -> out_valid with err=10 after 4 REQ cycles. A resp_valid injected later is ignored: no extra out_valid.
- Reset in WAIT: assert reset mid-cycle -> req_valid, busy and out_valid are 0 immediately. A resp_valid after release produces no out_valid; a fresh load then completes normally.
